serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 14 +
 rtl/addsub_slice.sv | 24 ++
 rtl/serial_addsub.sv | 118 +++++++++++
 tb/tb_serial_addsub.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the slice-serial adder/subtractor: controller states
// and the op encoding.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit ripple-carry adder used once per BUSY cycle.
module addsub_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  // A block-local carry variable keeps the chain from looking like a loop on one vector.
  always_comb begin
    logic v_c;
    s   = '0;
    v_c = cin;
    for (int i = 0; i < SLICE; i++) begin
      s[i] = x[i] ^ y[i] ^ v_c;
      v_c  = (x[i] & y[i]) | (v_c & (x[i] ^ y[i]));
    end
    cout = v_c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: operands are consumed SLICE bits per cycle
// through one addsub_slice, with the result presented on a valid/ready handshake.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = $clog2(N) + 1;

  if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_param_err
    $error("serial_addsub: SLICE must be >= 1 and divide WIDTH");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_step;
  logic [SLICE-1:0] w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_result_nxt;

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .x    (r_a[SLICE-1:0]),
    .y    (r_b[SLICE-1:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // New slice enters at the top so the first slice ends up in the LSBs after N steps.
  if (SLICE == WIDTH) begin : g_full
    assign w_result_nxt = w_s;
  end else begin : g_shift
    assign w_result_nxt = {w_s, r_result[WIDTH-1:SLICE]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // BUSY spends one extra cycle seeing r_cnt == N before handing over to DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: if (in_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = BUSY;
      end
      BUSY: if (r_cnt == CW'(N)) w_state_nxt = DONE;
            else                 w_step      = 1'b1;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b ^ {WIDTH{op}};
      r_carry  <= (op == OP_SUB);
      r_sign_a <= a[WIDTH-1];
      r_sign_b <= b[WIDTH-1] ^ op;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_a      <= r_a >> SLICE;
      r_b      <= r_b >> SLICE;
      r_result <= w_result_nxt;
      r_carry  <= w_cout;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign negative  = r_result[WIDTH-1];
  assign overflow  = (r_sign_a == r_sign_b) & (r_result[WIDTH-1] != r_sign_a);
  // Gated so a cleared result register does not report zero outside a completed result.
  assign zero      = out_valid & (r_result == '0);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at SLICE = 8, 1 and 32 sharing one stimulus stream.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        op = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic [2:0]        ir, ov, cy, vf, zr, ng;
  logic [2:0][31:0]  res;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_lat [3] = '{5, 33, 2};
  string nm [3] = '{"s8", "s1", "s32"};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs [9] = '{
    '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1},
    '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0},
    '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1},
    '{32'h0000_0007, 32'h0000_0003, 1'b1, 32'h0000_0004, 1'b1, 1'b0},
    '{32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0002, 1'b0, 1'b0}
  };

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(32), .SLICE(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .op(op), .out_valid(ov[0]), .out_ready(out_ready),
    .result(res[0]), .carry(cy[0]), .overflow(vf[0]), .zero(zr[0]), .negative(ng[0])
  );

  serial_addsub #(.WIDTH(32), .SLICE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .op(op), .out_valid(ov[1]), .out_ready(out_ready),
    .result(res[1]), .carry(cy[1]), .overflow(vf[1]), .zero(zr[1]), .negative(ng[1])
  );

  serial_addsub #(.WIDTH(32), .SLICE(32)) u_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .op(op), .out_valid(ov[2]), .out_ready(out_ready),
    .result(res[2]), .carry(cy[2]), .overflow(vf[2]), .zero(zr[2]), .negative(ng[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input logic [31:0] er, input logic ec, input logic ev);
    for (int d = 0; d < 3; d++) begin
      check_eq({nm[d], "_result"},   res[d],       er);
      check_eq({nm[d], "_carry"},    32'(cy[d]),   32'(ec));
      check_eq({nm[d], "_overflow"}, 32'(vf[d]),   32'(ev));
      check_eq({nm[d], "_zero"},     32'(zr[d]),   32'(er == 32'h0));
      check_eq({nm[d], "_negative"}, 32'(ng[d]),   32'(er[31]));
    end
  endtask

  task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                         input logic [31:0] er, input logic ec, input logic ev, input bit stall);
    int lat [3];
    lat = '{0, 0, 0};
    @(negedge clk);
    a = ta; b = tb_v; op = top; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++)
        if (ov[d] && lat[d] == 0) lat[d] = k;
      if (&ov) break;
    end
    for (int d = 0; d < 3; d++)
      check_eq({nm[d], "_latency"}, 32'(lat[d]), 32'(exp_lat[d]));
    check_outs(er, ec, ev);
    if (stall) begin
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        in_valid = 1'b1; a = ~ta; b = ta; op = ~top;
        @(posedge clk); #1;
        check_outs(er, ec, ev);
        check_eq("stall_in_ready", 32'(ir), 32'h0);
        check_eq("stall_out_valid", 32'(ov), 32'h7);
      end
      in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("post_hs_in_ready", 32'(ir), 32'h7);
    check_eq("post_hs_out_valid", 32'(ov), 32'h0);
  endtask

  initial begin
    int          seen;
    logic [31:0] ra, rb, er;
    logic        rop, ev;
    logic [32:0] full;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(ov), 32'h0);
    for (int d = 0; d < 3; d++) begin
      check_eq({nm[d], "_rst_result"}, res[d], 32'h0);
      check_eq({nm[d], "_rst_flags"}, {28'h0, cy[d], vf[d], zr[d], ng[d]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 32'(ir), 32'h7);

    foreach (vecs[i])
      run_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].c, vecs[i].v, (i == 4));

    // Abort: reset lands in the second BUSY cycle.
    @(negedge clk);
    a = 32'h1122_3344; b = 32'h0101_0101; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 32'(ov), 32'h0);
    for (int d = 0; d < 3; d++) begin
      check_eq({nm[d], "_abort_result"}, res[d], 32'h0);
      check_eq({nm[d], "_abort_flags"}, {28'h0, cy[d], vf[d], zr[d], ng[d]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (|ov) seen++;
    end
    check_eq("abort_no_out_valid", 32'(seen), 32'h0);
    check_eq("abort_in_ready", 32'(ir), 32'h7);
    run_txn(32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 1'($urandom_range(0, 1));
      full = rop ? ({1'b0, ra} + {1'b0, ~rb} + 33'd1) : ({1'b0, ra} + {1'b0, rb});
      er = full[31:0];
      ev = (ra[31] == (rb[31] ^ rop)) && (er[31] != ra[31]);
      run_txn(ra, rb, rop, er, full[32], ev, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before it");
    $fatal(1, "watchdog");
  end

endmodule
